// File: rtl/fan_pkg.sv
// Shared definitions for the fan tachometer meter: measurement FSM states and
// a constant-width helper used to size counters from parameters.
package fan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } fan_state_e;

  // Smallest bit count able to index 'value' distinct codes (ceil(log2(value))).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tach_debounce.sv
// Two-flop synchronizer, consecutive-sample filter and one-cycle rising-edge
// pulse for an asynchronous open-collector input such as a fan tach line.
module tach_debounce
  import fan_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tach_in,
  output logic edge_ev
);

  localparam int DW = clog2(DEBOUNCE + 32'sd1);
  localparam logic [DW-1:0] LAST_CNT = DW'(DEBOUNCE - 32'sd1);
  localparam logic [DW-1:0] CNT_ONE  = DW'(32'd1);
  localparam logic [DW-1:0] CNT_ZERO = {DW{1'b0}};

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic          edge_q, edge_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Filter: the level only follows the synced input after DEBOUNCE disagreeing samples in a row.
  always_comb begin
    sync1_d = tach_in;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    edge_d  = 1'b0;
    if (sync2_q == filt_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == LAST_CNT) begin
      filt_d = sync2_q;
      cnt_d  = CNT_ZERO;
      edge_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      edge_q  <= edge_d;
      cnt_q   <= cnt_d;
    end
  end

  assign edge_ev = edge_q;

endmodule

// File: rtl/fan_tach_meter.sv
// Fan tachometer meter: counts filtered tach rising edges across a window of
// GATE_TICKS timer ticks and publishes count, stall and overflow per window.
module fan_tach_meter
  import fan_pkg::*;
#(
  parameter int GATE_TICKS = 1000,
  parameter int CNT_W      = 16,
  parameter int DEBOUNCE   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic             tach_in,
  output logic [CNT_W-1:0] rpm_count,
  output logic             count_valid,
  output logic             stalled,
  output logic             overflow
);

  localparam int TW = clog2(GATE_TICKS + 32'sd1);
  localparam logic [TW-1:0]    LAST_TICK = TW'(GATE_TICKS - 32'sd1);
  localparam logic [TW-1:0]    TICK_ONE  = TW'(32'd1);
  localparam logic [TW-1:0]    TICK_ZERO = {TW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  fan_state_e       state_q, state_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rpm_q, rpm_d;
  logic             stalled_q, stalled_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;

  logic             edge_ev;
  logic             tick_ev;
  logic             sat_hit;
  logic [CNT_W-1:0] edge_next;
  logic             ovf_next;

  tach_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_tach_debounce (
    .clk    (clk),
    .reset  (reset),
    .tach_in(tach_in),
    .edge_ev(edge_ev)
  );

  assign tick_ev = tick & ~tick_q;

  // Window FSM; the edge arriving with the closing tick still belongs to the closing window.
  always_comb begin
    tick_d     = tick;
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    tick_cnt_d = tick_cnt_q;
    ovf_d      = ovf_q;
    rpm_d      = rpm_q;
    stalled_d  = stalled_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    sat_hit    = edge_ev && (edge_cnt_q == CNT_MAX);
    if (edge_ev && !sat_hit) begin
      edge_next = edge_cnt_q + CNT_ONE;
    end else begin
      edge_next = edge_cnt_q;
    end
    ovf_next = ovf_q | sat_hit;

    if (!enable) begin
      state_d    = IDLE;
      edge_cnt_d = CNT_ZERO;
      tick_cnt_d = TICK_ZERO;
      ovf_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ARM;
          edge_cnt_d = CNT_ZERO;
          tick_cnt_d = TICK_ZERO;
          ovf_d      = 1'b0;
        end
        ARM: begin
          if (tick_ev) begin
            state_d = GATE;
          end else begin
            state_d = ARM;
          end
          edge_cnt_d = CNT_ZERO;
          tick_cnt_d = TICK_ZERO;
          ovf_d      = 1'b0;
        end
        GATE: begin
          if (tick_ev && (tick_cnt_q == LAST_TICK)) begin
            rpm_d      = edge_next;
            stalled_d  = (edge_next == CNT_ZERO);
            overflow_d = ovf_next;
            valid_d    = 1'b1;
            edge_cnt_d = CNT_ZERO;
            tick_cnt_d = TICK_ZERO;
            ovf_d      = 1'b0;
          end else begin
            edge_cnt_d = edge_next;
            ovf_d      = ovf_next;
            if (tick_ev) begin
              tick_cnt_d = tick_cnt_q + TICK_ONE;
            end else begin
              tick_cnt_d = tick_cnt_q;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          edge_cnt_d = CNT_ZERO;
          tick_cnt_d = TICK_ZERO;
          ovf_d      = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= 1'b0;
      edge_cnt_q <= CNT_ZERO;
      tick_cnt_q <= TICK_ZERO;
      ovf_q      <= 1'b0;
      rpm_q      <= CNT_ZERO;
      stalled_q  <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      edge_cnt_q <= edge_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      ovf_q      <= ovf_d;
      rpm_q      <= rpm_d;
      stalled_q  <= stalled_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign rpm_count   = rpm_q;
  assign count_valid = valid_q;
  assign stalled     = stalled_q;
  assign overflow    = overflow_q;

endmodule
